pipe_stage_ctrl: RTL
====================

// Module: pipe_stage_ctrl
// PURPOSE
//  Sequencing controller for the 5-stage core pipeline (IF, IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Generates per-stage register enables and bubble (sync-clear) strobes.
//  Handles load-use stalls, multi-cycle memory-access freezes, and run/halt with pipeline drain.
//  One instance per core; sits beside the pipeline registers and drives their en/reset pins.
// PARAMETERS
//  REGFILE_ADDR_WIDTH  5   register-file address width
//  PIPE_DEPTH          5   stages to drain on halt; drain length = PIPE_DEPTH-1 cycles
//  CNT_WIDTH           32  stall-counter width
// PORTS
//  clk           in   1    clock
//  reset         in   1    synchronous, active-high reset
//  run_req       in   1    start fetching (sampled in IDLE)
//  halt_req      in   1    stop fetching and drain the pipe
//  id_rs_addr    in   RAW  ID-stage source A register (RAW = REGFILE_ADDR_WIDTH)
//  id_rt_addr    in   RAW  ID-stage source B register
//  id_uses_rs    in   1    ID instruction reads rs
//  id_uses_rt    in   1    ID instruction reads rt
//  ex_wr_addr    in   RAW  EX-stage destination register
//  ex_is_load    in   1    EX instruction is a load
//  mem_req       in   1    EX/MEM stage holds a memory access this cycle
//  mem_ack       in   1    memory access completes this cycle
//  pc_en         out  1    PC update enable
//  if_id_en      out  1    IF/ID enable
//  if_id_bubble  out  1    IF/ID sync clear (insert NOP)
//  id_ex_en      out  1    ID/EX enable
//  id_ex_bubble  out  1    ID/EX sync clear (insert NOP)
//  ex_mem_en     out  1    EX/MEM enable
//  mem_wb_en     out  1    MEM/WB enable
//  running       out  1    state is RUN, MEM_WAIT or DRAIN
//  halted        out  1    state is IDLE
//  stall_cycles  out  CNT_WIDTH  cycles with pc_en=0 while running (see CONFIGURATION)
// BEHAVIOUR
//  - States: IDLE, RUN, MEM_WAIT, DRAIN. State is registered; all enables are a combinational
//    decode of state plus the current-cycle inputs.
//  - Reset: state=IDLE, drain_cnt=0, halt_pend=0, stall_cycles=0.
//    In IDLE: all en=0, bubbles=0, running=0, halted=1.
//  - load_use = ex_is_load & ex_wr_addr!=0 &
//    ((id_uses_rs & id_rs_addr==ex_wr_addr) | (id_uses_rt & id_rt_addr==ex_wr_addr)).
//  - freeze = mem_req & ~mem_ack.
//  - IDLE -> RUN on run_req & ~halt_req. If both are asserted, halt wins and the state stays IDLE.
//  - RUN, per-cycle priority:
//    1. freeze: all en=0, no bubble; next state MEM_WAIT.
//    2. load_use: pc_en=0, if_id_en=0, id_ex_bubble=1, ex_mem_en=mem_wb_en=1.
//       This is a 1-cycle stall.
//    3. otherwise: all en=1.
//  - halt_req in RUN (not freeze) -> DRAIN with drain_cnt=PIPE_DEPTH-1.
//    The halt cycle itself behaves as a normal RUN cycle.
//  - MEM_WAIT:
//    - all en=0 while ~mem_ack.
//    - On mem_ack, apply the RUN decode for that cycle, then go to RUN, or to DRAIN if halt_pend.
//  - halt_req seen in MEM_WAIT sets halt_pend; halt_pend clears on DRAIN entry.
//  - DRAIN:
//    - pc_en=0, if_id_bubble=1, other en=1; load_use is ignored (it cannot occur on NOPs).
//    - drain_cnt decrements each non-frozen cycle.
//    - freeze holds all en=0 and holds the count.
//    - drain_cnt==0 at a clock edge -> IDLE.
//  - Bubbles assert only alongside the matching en=1.
//  - Reset mid-operation: IDLE on the next edge; pending halt and counters are discarded.
// CONFIGURATION
//  - PIPE_STALL_CNT_EN defined:
//    - stall_cycles increments on every cycle with running=1 and pc_en=0.
//    - It saturates at all-ones and clears on reset.
//  - Undefined: stall_cycles is tied to 0 and no counter logic is instantiated.
// STRUCTURE
//  - Shared header pipe_ctrl_defs.vh: state-encoding localparams (IDLE=2'd0, RUN=2'd1,
//    MEM_WAIT=2'd2, DRAIN=2'd3) and the PIPE_DEPTH default.
//  - Sub-module pipe_hazard_detect: combinational load_use compare.
//    Parameterised on REGFILE_ADDR_WIDTH; reused by the forwarding unit.
// TESTING
//  - reset=1 for 2 clk, then released -> halted=1, all en=0, stall_cycles=0.
//  - run_req pulse -> next cycle running=1, all en=1.
//    run_req & halt_req together in IDLE -> stays IDLE.
//  - RUN, ex_is_load=1, ex_wr_addr=5, id_uses_rs=1, id_rs_addr=5
//    -> pc_en=if_id_en=0, id_ex_bubble=1 for 1 cycle.
//    Same case with ex_wr_addr=0 -> no stall.
//  - RUN, mem_req=1, mem_ack=0 for 3 cycles, then mem_ack=1 -> all en=0 for 3 cycles,
//    en=1 on the ack cycle.
//    stall_cycles=3 with PIPE_STALL_CNT_EN, 0 without.
//  - halt_req in RUN -> 4 DRAIN cycles (pc_en=0, if_id_bubble=1), then halted=1.
//    halt_req during MEM_WAIT -> DRAIN entered after ack.
//  - reset asserted mid-DRAIN -> IDLE next cycle.
//    A following run_req resumes normally with a fresh drain count.

Source files
------------

// File: rtl/pipe_stage_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: state encoding,
// per-stage control bundle and the RUN-cycle enable decode.
package pipe_stage_ctrl_pkg;

  localparam int PIPE_DEPTH_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_DRAIN    = 2'd3
  } pipe_state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_bubble;
    logic id_ex_en;
    logic id_ex_bubble;
    logic ex_mem_en;
    logic mem_wb_en;
  } stage_ctl_t;

  // Non-frozen RUN cycle: a load-use hazard holds PC and IF/ID for one
  // cycle and pushes a NOP into ID/EX while the back end keeps moving.
  function automatic stage_ctl_t run_decode(input logic load_use);
    stage_ctl_t c;
    c              = '0;
    c.pc_en        = ~load_use;
    c.if_id_en     = ~load_use;
    c.id_ex_en     = 1'b1;
    c.id_ex_bubble = load_use;
    c.ex_mem_en    = 1'b1;
    c.mem_wb_en    = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipe_stage_ctrl_hazard_detect.sv
// Load-use hazard compare between the ID-stage sources and a load in EX.
// Purely combinational so the forwarding unit can share it.
module pipe_hazard_detect #(
  parameter int REGFILE_ADDR_WIDTH = 5
) (
  input  logic                          ex_is_load,
  input  logic [REGFILE_ADDR_WIDTH-1:0] ex_wr_addr,
  input  logic [REGFILE_ADDR_WIDTH-1:0] id_rs_addr,
  input  logic [REGFILE_ADDR_WIDTH-1:0] id_rt_addr,
  input  logic                          id_uses_rs,
  input  logic                          id_uses_rt,
  output logic                          load_use
);

  // Register 0 is hard-wired zero, so a load targeting it never conflicts.
  assign load_use = ex_is_load && (ex_wr_addr != '0) &&
                    ((id_uses_rs && (id_rs_addr == ex_wr_addr)) ||
                     (id_uses_rt && (id_rt_addr == ex_wr_addr)));

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Five-stage pipeline sequencer: stage enables/bubbles, load-use stall,
// memory freeze, halt with drain. Define PIPE_STALL_CNT_EN for stall_cycles.
//
//   state    | meaning
//   IDLE     | halted, all stage registers held
//   RUN      | normal issue, load-use stalls inserted as needed
//   MEM_WAIT | memory access outstanding, whole pipe frozen
//   DRAIN    | fetch stopped, NOPs fed in until the pipe is empty
module pipe_stage_ctrl
  import pipe_stage_ctrl_pkg::*;
#(
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int PIPE_DEPTH         = PIPE_DEPTH_DEF,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run_req,
  input  logic                          halt_req,
  input  logic [REGFILE_ADDR_WIDTH-1:0] id_rs_addr,
  input  logic [REGFILE_ADDR_WIDTH-1:0] id_rt_addr,
  input  logic                          id_uses_rs,
  input  logic                          id_uses_rt,
  input  logic [REGFILE_ADDR_WIDTH-1:0] ex_wr_addr,
  input  logic                          ex_is_load,
  input  logic                          mem_req,
  input  logic                          mem_ack,
  output logic                          pc_en,
  output logic                          if_id_en,
  output logic                          if_id_bubble,
  output logic                          id_ex_en,
  output logic                          id_ex_bubble,
  output logic                          ex_mem_en,
  output logic                          mem_wb_en,
  output logic                          running,
  output logic                          halted,
  output logic [CNT_WIDTH-1:0]          stall_cycles
);

  localparam int DW = $clog2(PIPE_DEPTH + 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(PIPE_DEPTH - 1);

  pipe_state_e   state, state_nx;
  logic [DW-1:0] drain_cnt, drain_cnt_nx;
  logic          halt_pend, halt_pend_nx;
  logic          load_use, freeze;
  stage_ctl_t    ctl;

  pipe_hazard_detect #(.REGFILE_ADDR_WIDTH(REGFILE_ADDR_WIDTH)) u_hazard (
    .ex_is_load (ex_is_load),
    .ex_wr_addr (ex_wr_addr),
    .id_rs_addr (id_rs_addr),
    .id_rt_addr (id_rt_addr),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .load_use   (load_use)
  );

  assign freeze = mem_req && !mem_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
      halt_pend <= 1'b0;
    end else begin
      state     <= state_nx;
      drain_cnt <= drain_cnt_nx;
      halt_pend <= halt_pend_nx;
    end
  end

  always_comb begin
    ctl          = '0;
    state_nx     = state;
    drain_cnt_nx = drain_cnt;
    halt_pend_nx = halt_pend;
    case (state)
      ST_IDLE: begin
        if (run_req && !halt_req) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (freeze) begin
          state_nx = ST_MEM_WAIT;
          if (halt_req) halt_pend_nx = 1'b1;
        end else begin
          ctl = run_decode(load_use);
          if (halt_req) begin
            state_nx     = ST_DRAIN;
            drain_cnt_nx = DRAIN_LOAD;
            halt_pend_nx = 1'b0;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_ack) begin
          if (halt_req) halt_pend_nx = 1'b1;
        end else begin
          ctl = run_decode(load_use);
          if (halt_pend || halt_req) begin
            state_nx     = ST_DRAIN;
            drain_cnt_nx = DRAIN_LOAD;
            halt_pend_nx = 1'b0;
          end else begin
            state_nx = ST_RUN;
          end
        end
      end
      ST_DRAIN: begin
        if (!freeze) begin
          ctl.if_id_en     = 1'b1;
          ctl.if_id_bubble = 1'b1;
          ctl.id_ex_en     = 1'b1;
          ctl.ex_mem_en    = 1'b1;
          ctl.mem_wb_en    = 1'b1;
          // Leave on the edge where the count reaches zero: PIPE_DEPTH-1 cycles.
          if (drain_cnt <= DW'(1)) begin
            state_nx     = ST_IDLE;
            drain_cnt_nx = '0;
          end else begin
            drain_cnt_nx = drain_cnt - DW'(1);
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign pc_en        = ctl.pc_en;
  assign if_id_en     = ctl.if_id_en;
  assign if_id_bubble = ctl.if_id_bubble;
  assign id_ex_en     = ctl.id_ex_en;
  assign id_ex_bubble = ctl.id_ex_bubble;
  assign ex_mem_en    = ctl.ex_mem_en;
  assign mem_wb_en    = ctl.mem_wb_en;
  assign running      = (state != ST_IDLE);
  assign halted       = (state == ST_IDLE);

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (running && !ctl.pc_en && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_WIDTH'(1);
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
